// File: rtl/twiddle_stage_ctrl_if.sv
// twiddle_stage_ctrl_if: bus bundle between the stage sequencer and its
// surroundings (sample RAM read/write ports, twiddle multiplier, control).
// master = sequencer side, slave = environment side.
interface twiddle_stage_ctrl_if;
  // control
  logic       i_start;
  logic [2:0] i_stage;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  // sample RAM read port
  logic [4:0] o_rd_addr;
  logic [7:0] i_rd_re;
  logic [7:0] i_rd_im;
  // twiddle multiplier
  logic [7:0] o_x;
  logic [7:0] o_y;
  logic [7:0] o_c;
  logic [8:0] o_c_plus_s;
  logic [8:0] o_c_minus_s;
  logic       o_mult_start;
  logic       i_mult_valid;
  logic [7:0] i_mult_re;
  logic [7:0] i_mult_im;
  // sample RAM write port
  logic       o_wr_en;
  logic [4:0] o_wr_addr;
  logic [7:0] o_wr_re;
  logic [7:0] o_wr_im;

  modport master (
    input  i_start, i_stage, i_rd_re, i_rd_im, i_mult_valid, i_mult_re, i_mult_im,
    output o_busy, o_done, o_err, o_rd_addr, o_x, o_y, o_c, o_c_plus_s, o_c_minus_s,
           o_mult_start, o_wr_en, o_wr_addr, o_wr_re, o_wr_im
  );

  modport slave (
    output i_start, i_stage, i_rd_re, i_rd_im, i_mult_valid, i_mult_re, i_mult_im,
    input  o_busy, o_done, o_err, o_rd_addr, o_x, o_y, o_c, o_c_plus_s, o_c_minus_s,
           o_mult_start, o_wr_en, o_wr_addr, o_wr_re, o_wr_im
  );
endinterface

// File: rtl/twiddle_stage_ctrl.sv
// twiddle_stage_ctrl: sequences the 16 butterflies of one radix-2 DIT stage of
// a 32-point FFT. For each butterfly it reads the bottom operand, looks up the
// Q1.7 twiddle, runs the external twiddle multiplier and writes the rotated
// product back to the bottom address.
// Build option: define TWIDDLE_BYPASS_EN to skip the multiplier for twiddle
// index 0 and write the RAM data back unchanged (exact multiply by 1).
module twiddle_stage_ctrl #(
  parameter int RAM_LAT = 1,  // sample-RAM read latency, 1..3
  parameter int DATA_W  = 8   // fixed by the multiplier
) (
  input  logic                clk,
  input  logic                rst_n,
  twiddle_stage_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LAT, S_START, S_WAIT, S_WR, S_DONE
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

  state_t            state_reg, state_next;
  logic [3:0]        b_reg, b_next;
  logic [2:0]        stage_reg, stage_next;
  logic [1:0]        lat_reg, lat_next;
  logic [4:0]        rd_addr_reg, rd_addr_next;
  logic [4:0]        wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] x_reg, x_next, y_reg, y_next, c_reg, c_next;
  logic [DATA_W:0]   cps_reg, cps_next, cms_reg, cms_next;
  logic [DATA_W-1:0] wr_re_reg, wr_re_next, wr_im_reg, wr_im_next;
  logic              err_reg, err_next;
  logic [3:0]        k_cur;
  logic [7:0]        rom_c, rom_s;

  // Bottom address of butterfly b at stage s: top + half.
  function automatic logic [4:0] bot_of(input logic [3:0] b, input logic [2:0] s);
    logic [5:0] half, pos, top;
    half = 6'd1 << s;
    pos  = {2'b00, b} & (half - 6'd1);
    top  = (({2'b00, b} >> s) << (s + 3'd1)) + pos;
    return 5'(top + half);
  endfunction

  // Twiddle index: position inside the group, scaled to the 16-entry ROM.
  function automatic logic [3:0] k_of(input logic [3:0] b, input logic [2:0] s);
    logic [3:0] mask;
    mask = 4'((5'd1 << s) - 5'd1);
    return 4'((b & mask) << (3'd4 - s));
  endfunction

  assign k_cur = k_of(b_reg, stage_reg);

  // Twiddle ROM: c = min(127, round(128cos)), s = clamp(round(-128sin)).
  always_comb begin
    rom_c = 8'd0;
    rom_s = 8'd0;
    case (k_cur)
      4'd0:  begin rom_c =  8'sd127; rom_s =  8'sd0;   end
      4'd1:  begin rom_c =  8'sd126; rom_s = -8'sd25;  end
      4'd2:  begin rom_c =  8'sd118; rom_s = -8'sd49;  end
      4'd3:  begin rom_c =  8'sd106; rom_s = -8'sd71;  end
      4'd4:  begin rom_c =  8'sd91;  rom_s = -8'sd91;  end
      4'd5:  begin rom_c =  8'sd71;  rom_s = -8'sd106; end
      4'd6:  begin rom_c =  8'sd49;  rom_s = -8'sd118; end
      4'd7:  begin rom_c =  8'sd25;  rom_s = -8'sd126; end
      4'd8:  begin rom_c =  8'sd0;   rom_s =  8'h80;   end
      4'd9:  begin rom_c = -8'sd25;  rom_s = -8'sd126; end
      4'd10: begin rom_c = -8'sd49;  rom_s = -8'sd118; end
      4'd11: begin rom_c = -8'sd71;  rom_s = -8'sd106; end
      4'd12: begin rom_c = -8'sd91;  rom_s = -8'sd91;  end
      4'd13: begin rom_c = -8'sd106; rom_s = -8'sd71;  end
      4'd14: begin rom_c = -8'sd118; rom_s = -8'sd49;  end
      default: begin rom_c = -8'sd126; rom_s = -8'sd25; end
    endcase
  end

  // Next-state logic and next values of all held/registered outputs.
  always_comb begin
    state_next   = state_reg;
    b_next       = b_reg;
    stage_next   = stage_reg;
    lat_next     = lat_reg;
    rd_addr_next = rd_addr_reg;
    wr_addr_next = wr_addr_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    c_next       = c_reg;
    cps_next     = cps_reg;
    cms_next     = cms_reg;
    wr_re_next   = wr_re_reg;
    wr_im_next   = wr_im_reg;
    err_next     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_stage <= 3'd4) begin
            stage_next   = bus.i_stage;
            b_next       = 4'd0;
            rd_addr_next = bot_of(4'd0, bus.i_stage);
            state_next   = S_RD;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_RD: begin
        lat_next   = 2'd0;
        state_next = S_LAT;
      end
      S_LAT: begin
        if (lat_reg == LAT_LAST) begin
          x_next     = bus.i_rd_re;
          y_next     = bus.i_rd_im;
          c_next     = rom_c;
          cps_next   = {rom_c[7], rom_c} + {rom_s[7], rom_s};
          cms_next   = {rom_c[7], rom_c} - {rom_s[7], rom_s};
          state_next = S_START;
`ifdef TWIDDLE_BYPASS_EN
          if (k_cur == 4'd0) begin
            wr_addr_next = rd_addr_reg;
            wr_re_next   = bus.i_rd_re;
            wr_im_next   = bus.i_rd_im;
            state_next   = S_WR;
          end
`endif
        end else begin
          lat_next = lat_reg + 2'd1;
        end
      end
      S_START: state_next = S_WAIT;
      S_WAIT: begin
        if (bus.i_mult_valid) begin
          wr_addr_next = rd_addr_reg;
          wr_re_next   = bus.i_mult_re;
          wr_im_next   = bus.i_mult_im;
          state_next   = S_WR;
        end
      end
      S_WR: begin
        if (b_reg == 4'd15) begin
          state_next = S_DONE;
        end else begin
          b_next       = b_reg + 4'd1;
          rd_addr_next = bot_of(b_reg + 4'd1, stage_reg);
          state_next   = S_RD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any stage in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      b_reg       <= '0;
      stage_reg   <= '0;
      lat_reg     <= '0;
      rd_addr_reg <= '0;
      wr_addr_reg <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      c_reg       <= '0;
      cps_reg     <= '0;
      cms_reg     <= '0;
      wr_re_reg   <= '0;
      wr_im_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      b_reg       <= b_next;
      stage_reg   <= stage_next;
      lat_reg     <= lat_next;
      rd_addr_reg <= rd_addr_next;
      wr_addr_reg <= wr_addr_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      c_reg       <= c_next;
      cps_reg     <= cps_next;
      cms_reg     <= cms_next;
      wr_re_reg   <= wr_re_next;
      wr_im_reg   <= wr_im_next;
      err_reg     <= err_next;
    end
  end

  assign bus.o_rd_addr    = rd_addr_reg;
  assign bus.o_x          = x_reg;
  assign bus.o_y          = y_reg;
  assign bus.o_c          = c_reg;
  assign bus.o_c_plus_s   = cps_reg;
  assign bus.o_c_minus_s  = cms_reg;
  assign bus.o_mult_start = (state_reg == S_START);
  assign bus.o_wr_en      = (state_reg == S_WR);
  assign bus.o_wr_addr    = wr_addr_reg;
  assign bus.o_wr_re      = wr_re_reg;
  assign bus.o_wr_im      = wr_im_reg;
  assign bus.o_busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign bus.o_done       = (state_reg == S_DONE);
  assign bus.o_err        = err_reg;

endmodule

// File: tb/tb_twiddle_stage_ctrl.sv
// tb_twiddle_stage_ctrl: randomized scoreboard bench. A stage planner computes
// every expected coefficient set and write from the FFT indexing rules and a
// real-valued twiddle formula; a negedge monitor pops and compares them as the
// DUT presents o_mult_start / o_wr_en / o_done.
module tb_twiddle_stage_ctrl;
  localparam int RAM_LAT = 2;
`ifdef TWIDDLE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  twiddle_stage_ctrl_if bus ();
  twiddle_stage_ctrl #(.RAM_LAT(RAM_LAT), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  int ref_re [32];
  int ref_im [32];

  function automatic int rnd(input real v);
    if (v >= 0.0) return int'($floor(v + 0.5));
    else          return -int'($floor(-v + 0.5));
  endfunction

  function automatic void twiddle(input int k, output int c, output int s);
    real a;
    a = 2.0 * 3.14159265358979 * real'(k) / 32.0;
    c = rnd(128.0 * $cos(a));
    if (c > 127) c = 127;
    s = rnd(-128.0 * $sin(a));
    if (s > 127) s = 127;
    if (s < -128) s = -128;
  endfunction

  function automatic logic [15:0] rotate(input int x, input int y, input int c, input int s);
    int re, im;
    re = (x * c - y * s) >>> 7;
    im = (x * s + y * c) >>> 7;
    return {re[7:0], im[7:0]};
  endfunction

  // ---------------- sample RAM model ----------------
  logic [7:0]  ram_re [32];
  logic [7:0]  ram_im [32];
  logic [15:0] rd_pipe [RAM_LAT];
  logic        ram_load = 1'b0;

  always @(posedge clk) begin
    rd_pipe[0] <= {ram_re[bus.o_rd_addr], ram_im[bus.o_rd_addr]};
    for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (ram_load) begin
      for (int i = 0; i < 32; i++) begin
        ram_re[i] <= 8'(ref_re[i]);
        ram_im[i] <= 8'(ref_im[i]);
      end
    end else if (bus.o_wr_en) begin
      ram_re[bus.o_wr_addr] <= bus.o_wr_re;
      ram_im[bus.o_wr_addr] <= bus.o_wr_im;
    end
  end
  assign bus.i_rd_re = rd_pipe[RAM_LAT-1][15:8];
  assign bus.i_rd_im = rd_pipe[RAM_LAT-1][7:0];

  // ---------------- multiplier model ----------------
  int          m_lat = 3;
  int          mcnt;
  logic        mv_q, spur;
  logic [7:0]  mult_re_q, mult_im_q;
  logic [41:0] mop;
  logic [41:0] cur_op;
  assign cur_op = {bus.o_x, bus.o_y, bus.o_c, bus.o_c_plus_s, bus.o_c_minus_s};

  function automatic logic [15:0] rotate_op(input logic [41:0] op);
    int x, y, c, cps;
    x   = int'($signed(op[41:34]));
    y   = int'($signed(op[33:26]));
    c   = int'($signed(op[25:18]));
    cps = int'($signed(op[17:9]));
    return rotate(x, y, c, cps - c);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0;
      mv_q <= 1'b0;
    end else begin
      mv_q      <= 1'b0;
      mult_re_q <= 8'($urandom);
      mult_im_q <= 8'($urandom);
      if (bus.o_mult_start) begin
        mop <= cur_op;
        if (m_lat == 1) begin
          mv_q <= 1'b1;
          {mult_re_q, mult_im_q} <= rotate_op(cur_op);
        end else begin
          mcnt <= m_lat - 1;
        end
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          mv_q <= 1'b1;
          {mult_re_q, mult_im_q} <= rotate_op(mop);
        end
      end
    end
  end
  assign bus.i_mult_valid = mv_q | spur;
  assign bus.i_mult_re    = mult_re_q;
  assign bus.i_mult_im    = mult_im_q;

  // ---------------- scoreboard monitor ----------------
  logic [41:0] coef_q [$];
  logic [20:0] wr_q   [$];
  logic [41:0] mon_coef;
  logic [20:0] mon_wr;
  int done_cnt = 0, done_cyc = 0, err_cnt = 0, busy_cnt = 0, start_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_err)  err_cnt++;
      if (mcnt > 0 || mv_q) check("operands_held", cur_op, mop);
      if (bus.o_mult_start) begin
        start_cnt++;
        check("start_expected", 128'(coef_q.size() > 0), 1);
        if (coef_q.size() > 0) begin
          mon_coef = coef_q.pop_front();
          check("coef", cur_op, mon_coef);
        end
      end
      if (bus.o_wr_en) begin
        $display("wr addr=%0d re=%02h im=%02h", bus.o_wr_addr, bus.o_wr_re, bus.o_wr_im);
        check("write_expected", 128'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          mon_wr = wr_q.pop_front();
          check("write", {bus.o_wr_addr, bus.o_wr_re, bus.o_wr_im}, mon_wr);
        end
      end
      if (bus.o_done) begin
        check("done_not_busy", bus.o_busy, 0);
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      check("no_write_in_reset", bus.o_wr_en, 0);
    end
  end

  // ---------------- stimulus ----------------
  logic [72:0] all_outs;
  assign all_outs = {bus.o_rd_addr, cur_op, bus.o_mult_start, bus.o_wr_en, bus.o_wr_addr,
                     bus.o_wr_re, bus.o_wr_im, bus.o_busy, bus.o_done, bus.o_err};

  // Push expectations for a whole stage and return its start-to-done length.
  task automatic plan_stage(input int s, input int m, output int exp_cycles);
    int half, pos, bot, k, c, sn, x, y;
    logic [15:0] w;
    exp_cycles = 1;
    half = 1 << s;
    for (int b = 0; b < 16; b++) begin
      pos = b % half;
      bot = (b / half) * 2 * half + pos + half;
      k   = pos * 16 / half;
      twiddle(k, c, sn);
      x = ref_re[bot];
      y = ref_im[bot];
      if (BYPASS && k == 0) begin
        w = {8'(x), 8'(y)};
        exp_cycles += 2 + RAM_LAT;
      end else begin
        coef_q.push_back({8'(x), 8'(y), 8'(c), 9'(c + sn), 9'(c - sn)});
        w = rotate(x, y, c, sn);
        exp_cycles += 3 + RAM_LAT + m;
      end
      wr_q.push_back({5'(bot), w});
      ref_re[bot] = int'($signed(w[15:8]));
      ref_im[bot] = int'($signed(w[7:0]));
    end
  endtask

  task automatic pulse_start(input int s, output int t0);
    bus.i_stage = 3'(s);
    bus.i_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_stage = 3'($urandom);
  endtask

  task automatic run_stage(input int s, input int m);
    int ec, t0, d0;
    plan_stage(s, m, ec);
    m_lat = m;
    d0 = done_cnt;
    pulse_start(s, t0);
    for (int t = 0; t < 3000 && done_cnt == d0; t++) begin
      @(posedge clk); #1;
    end
    $display("stage %0d M=%0d: done after %0d cycles (model %0d)", s, m, done_cyc - t0, ec);
    check("stage_done", 128'(done_cnt - d0), 1);
    check("stage_latency", 128'(done_cyc - t0), 128'(ec));
    check("coef_left", 128'(coef_q.size()), 0);
    check("write_left", 128'(wr_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic err_test(input int s);
    int e0, b0, t0;
    e0 = err_cnt;
    b0 = busy_cnt;
    pulse_start(s, t0);
    repeat (4) @(posedge clk);
    #1;
    $display("bad stage %0d: err pulses=%0d busy cycles=%0d", s, err_cnt - e0, busy_cnt - b0);
    check("err_pulse", 128'(err_cnt - e0), 1);
    check("err_not_busy", 128'(busy_cnt - b0), 0);
  endtask

  task automatic abort_test();
    int ec, t0, s0, b0;
    plan_stage(2, 6, ec);
    m_lat = 6;
    s0 = start_cnt;
    pulse_start(2, t0);
    for (int t = 0; t < 500 && start_cnt - s0 < 3; t++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #2;
    check("abort_in_wait", 128'(mcnt > 0), 1);
    rst_n = 1'b0;
    #1;
    $display("abort in WAIT: outputs=%0h", all_outs);
    check("abort_outputs_zero", all_outs, 0);
    repeat (3) @(posedge clk);
    #1;
    coef_q.delete();
    wr_q.delete();
    rst_n = 1'b1;
    b0 = busy_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("abort_stays_idle", 128'(busy_cnt - b0), 0);
    for (int i = 0; i < 32; i++) begin
      ref_re[i] = int'($signed(ram_re[i]));
      ref_im[i] = int'($signed(ram_im[i]));
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_stage = 3'd0;
    spur        = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ref_re[i] = (i % 2 == 1) ? 64  : int'($urandom_range(0, 255)) - 128;
      ref_im[i] = (i % 2 == 1) ? -32 : int'($urandom_range(0, 255)) - 128;
    end
    ram_load = 1'b1;
    #1;
    check("reset_outputs_zero", all_outs, 0);
    repeat (2) @(posedge clk);
    #1;
    ram_load = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    // a stray valid while idle must be ignored
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;

    run_stage(0, 3);
    run_stage(4, 2);
    run_stage(3, 1);
    run_stage(1, 4);
    run_stage(2, 3);
    err_test(6);
    err_test(5);
    err_test(7);
    abort_test();
    run_stage(2, 3);
    for (int n = 0; n < 8; n++) begin
      run_stage(int'($urandom_range(0, 4)), int'($urandom_range(1, 5)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
